// File: rtl/dla_seq_pkg.sv
// Shared types for the DLA layer sequencer: the packed layer descriptor and
// the sequencer state encoding.
package dla_seq_pkg;

  localparam int DESC_W = 36;

  typedef struct packed {
    logic [5:0]  layer_id;
    logic [1:0]  layer_type;
    logic [15:0] tile_n;
    logic [7:0]  rows_per_tile;
    logic [3:0]  flags;
  } desc_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ISSUE = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
  } seq_state_e;

endpackage

// File: rtl/dla_desc_fifo.sv
// Show-ahead synchronous FIFO with flush; DEPTH must be a power of two so the
// read/write pointers wrap naturally.
module dla_desc_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 36
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A push is refused whenever full, even if a pop happens in the same cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_d = count_q + CW'(1);
      else if (!do_push && do_pop) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/dla_layer_sequencer.sv
// Queues layer descriptors, issues each as a one-cycle uLD load and derives the
// per-tile context (first/last, row offset, bias, PPU) from pass completions.
module dla_layer_sequencer
  import dla_seq_pkg::*;
#(
  parameter int DESC_DEPTH = 4,
  parameter int TILE_W     = 16,
  parameter int ROW_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run_en_i,
  input  logic              abort_i,
  input  logic              desc_valid_i,
  output logic              desc_ready_o,
  input  logic [DESC_W-1:0] desc_i,
  output logic              uld_en_o,
  output logic [5:0]        layer_id_o,
  output logic [1:0]        layer_type_o,
  output logic [3:0]        flags_o,
  input  logic              pass_done_i,
  output logic              n_tile_is_first_o,
  output logic              n_tile_is_last_o,
  output logic [ROW_W-1:0]  already_compute_row_o,
  output logic              is_bias_o,
  output logic              need_ppu_o,
  output logic              layer_done_o,
  output logic              busy_o,
  output logic              err_o
);

  localparam int CNT_W = $clog2(DESC_DEPTH) + 1;

  seq_state_e       state_q, state_d;
  desc_t            head;
  logic             fifo_full, fifo_empty, fifo_pop;
  logic [CNT_W-1:0] fifo_count;
  logic             push_ok, q_avail;

  logic [5:0]        layer_id_q, layer_id_d;
  logic [1:0]        layer_type_q, layer_type_d;
  logic [3:0]        flags_q, flags_d;
  logic [7:0]        rows_q, rows_d;
  logic [TILE_W-1:0] tile_n_q, tile_n_d;
  logic [TILE_W-1:0] tile_idx_q, tile_idx_d;
  logic [TILE_W-1:0] head_tile_n, last_idx;
  logic [ROW_W-1:0]  row_acc_q, row_acc_d;
  logic              err_q, err_d;
  logic              ctx_valid, is_first, is_last;

  // Descriptor handshake: a descriptor is taken on any cycle where
  // desc_valid_i && desc_ready_o; a push while not ready is dropped, not held.
  dla_desc_fifo #(
    .DEPTH (DESC_DEPTH),
    .WIDTH (DESC_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (abort_i),
    .push_i  (desc_valid_i),
    .pop_i   (fifo_pop),
    .wdata_i (desc_i),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Counting the push in flight lets a descriptor pushed into an idle,
  // empty queue reach LOAD on the very next cycle.
  assign push_ok     = desc_valid_i && !fifo_full;
  assign q_avail     = (fifo_count != '0) || push_ok;
  assign head_tile_n = TILE_W'(head.tile_n);
  assign last_idx    = tile_n_q - TILE_W'(1);

  always_comb begin
    state_d      = state_q;
    layer_id_d   = layer_id_q;
    layer_type_d = layer_type_q;
    flags_d      = flags_q;
    rows_d       = rows_q;
    tile_n_d     = tile_n_q;
    tile_idx_d   = tile_idx_q;
    row_acc_d    = row_acc_q;
    err_d        = err_q;
    fifo_pop     = 1'b0;
    uld_en_o     = 1'b0;
    layer_done_o = 1'b0;

    if (abort_i) begin
      state_d      = S_IDLE;
      layer_id_d   = '0;
      layer_type_d = '0;
      flags_d      = '0;
      rows_d       = '0;
      tile_n_d     = '0;
      tile_idx_d   = '0;
      row_acc_d    = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (run_en_i && q_avail) state_d = S_LOAD;
        end
        S_LOAD: begin
          fifo_pop = !fifo_empty;
          if (head_tile_n == '0) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            layer_id_d   = head.layer_id;
            layer_type_d = head.layer_type;
            flags_d      = head.flags;
            rows_d       = head.rows_per_tile;
            tile_n_d     = head_tile_n;
            tile_idx_d   = '0;
            row_acc_d    = '0;
            state_d      = S_ISSUE;
          end
        end
        S_ISSUE: begin
          uld_en_o = 1'b1;
          state_d  = S_RUN;
        end
        S_RUN: begin
          if (pass_done_i) begin
            if (tile_idx_q == last_idx) begin
              state_d = S_DONE;
            end else begin
              tile_idx_d = tile_idx_q + TILE_W'(1);
              row_acc_d  = row_acc_q + ROW_W'(rows_q);
            end
          end
        end
        S_DONE: begin
          layer_done_o = 1'b1;
          state_d      = (run_en_i && q_avail) ? S_LOAD : S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      layer_id_q   <= '0;
      layer_type_q <= '0;
      flags_q      <= '0;
      rows_q       <= '0;
      tile_n_q     <= '0;
      tile_idx_q   <= '0;
      row_acc_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      layer_id_q   <= layer_id_d;
      layer_type_q <= layer_type_d;
      flags_q      <= flags_d;
      rows_q       <= rows_d;
      tile_n_q     <= tile_n_d;
      tile_idx_q   <= tile_idx_d;
      row_acc_q    <= row_acc_d;
      err_q        <= err_d;
    end
  end

  // Tile context is only meaningful while a layer is issued or running.
  assign ctx_valid = (state_q == S_ISSUE) || (state_q == S_RUN);
  assign is_first  = ctx_valid && (tile_idx_q == '0);
  assign is_last   = ctx_valid && (tile_idx_q == last_idx);

  assign n_tile_is_first_o     = is_first;
  assign n_tile_is_last_o      = is_last;
  assign is_bias_o             = flags_q[3] && is_first;
  assign need_ppu_o            = is_last && (flags_q[0] || flags_q[2]);
  assign already_compute_row_o = row_acc_q;
  assign layer_id_o            = layer_id_q;
  assign layer_type_o          = layer_type_q;
  assign flags_o               = flags_q;
  assign desc_ready_o          = !fifo_full;
  assign busy_o                = (state_q != S_IDLE);
  assign err_o                 = err_q;

endmodule

// File: tb/tb_dla_layer_sequencer.sv
// Randomised scoreboard bench for dla_layer_sequencer: the driver queues the
// expected layer loads, a negedge monitor pops them and tracks tile context.
module tb_dla_layer_sequencer;
  import dla_seq_pkg::*;

  localparam int DEPTH  = 4;
  localparam int TILE_W = 16;
  localparam int ROW_W  = 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              run_en_i, abort_i, desc_valid_i, desc_ready_o;
  logic [DESC_W-1:0] desc_i;
  logic              uld_en_o;
  logic [5:0]        layer_id_o;
  logic [1:0]        layer_type_o;
  logic [3:0]        flags_o;
  logic              pass_done_i;
  logic              n_tile_is_first_o, n_tile_is_last_o;
  logic [ROW_W-1:0]  already_compute_row_o;
  logic              is_bias_o, need_ppu_o, layer_done_o, busy_o, err_o;

  dla_layer_sequencer #(
    .DESC_DEPTH (DEPTH),
    .TILE_W     (TILE_W),
    .ROW_W      (ROW_W)
  ) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .run_en_i              (run_en_i),
    .abort_i               (abort_i),
    .desc_valid_i          (desc_valid_i),
    .desc_ready_o          (desc_ready_o),
    .desc_i                (desc_i),
    .uld_en_o              (uld_en_o),
    .layer_id_o            (layer_id_o),
    .layer_type_o          (layer_type_o),
    .flags_o               (flags_o),
    .pass_done_i           (pass_done_i),
    .n_tile_is_first_o     (n_tile_is_first_o),
    .n_tile_is_last_o      (n_tile_is_last_o),
    .already_compute_row_o (already_compute_row_o),
    .is_bias_o             (is_bias_o),
    .need_ppu_o            (need_ppu_o),
    .layer_done_o          (layer_done_o),
    .busy_o                (busy_o),
    .err_o                 (err_o)
  );

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [DESC_W-1:0] exp_q[$];
  int m_occ = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DESC_W-1:0] mk(input logic [5:0] id, input logic [1:0] ty,
                                           input logic [15:0] tn, input logic [7:0] rows,
                                           input logic [3:0] fl);
    return {id, ty, tn, rows, fl};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DESC_W-1:0] d);
    desc_t dd;
    logic  accept;
    accept       = (m_occ < DEPTH);
    dd           = d;
    desc_valid_i = 1'b1;
    desc_i       = d;
    tick();
    desc_valid_i = 1'b0;
    if (accept) begin
      m_occ++;
      if (dd.tile_n != 16'd0) exp_q.push_back(d);
    end
  endtask

  task automatic run_until_idle(input int budget);
    int cyc = 0;
    int quiet = 0;
    while (quiet < 3 && cyc < budget) begin
      pass_done_i = busy_o ? ($urandom_range(0, 2) == 0) : 1'b0;
      tick();
      cyc++;
      if (!busy_o) quiet++;
      else quiet = 0;
    end
    pass_done_i = 1'b0;
    check("drain_idle", busy_o, 1'b0);
    check("drain_all_issued", exp_q.size(), 0);
    m_occ = 0;
  endtask

  task automatic wait_uld(input int budget);
    int c = 0;
    while (!uld_en_o && c < budget) begin
      tick();
      c++;
    end
    check("uld_wait", uld_en_o, 1'b1);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_uld"},   uld_en_o, 1'b0);
    check({tag, "_id"},    layer_id_o, 6'd0);
    check({tag, "_type"},  layer_type_o, 2'd0);
    check({tag, "_flags"}, flags_o, 4'd0);
    check({tag, "_first"}, n_tile_is_first_o, 1'b0);
    check({tag, "_last"},  n_tile_is_last_o, 1'b0);
    check({tag, "_acc"},   already_compute_row_o, '0);
    check({tag, "_bias"},  is_bias_o, 1'b0);
    check({tag, "_ppu"},   need_ppu_o, 1'b0);
    check({tag, "_done"},  layer_done_o, 1'b0);
    check({tag, "_busy"},  busy_o, 1'b0);
    check({tag, "_err"},   err_o, 1'b0);
    check({tag, "_ready"}, desc_ready_o, 1'b1);
  endtask

  // ---------------- monitor / reference model ----------------
  bit               in_layer = 1'b0;
  bit               done_pending = 1'b0;
  bit               fresh;
  int               m_tile;
  desc_t            m_desc;
  logic [ROW_W-1:0] m_acc;
  logic             m_first, m_last;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_layer     = 1'b0;
      done_pending = 1'b0;
      exp_q.delete();
    end else begin
      check("layer_done", layer_done_o, done_pending);
      done_pending = 1'b0;
      fresh = 1'b0;
      if (exp_q.size() == 0) begin
        check("uld_unexpected", uld_en_o, 1'b0);
      end else if (uld_en_o) begin
        m_desc = exp_q.pop_front();
        check("uld_layer_id", layer_id_o, m_desc.layer_id);
        check("uld_layer_type", layer_type_o, m_desc.layer_type);
        check("uld_flags", flags_o, m_desc.flags);
        in_layer = 1'b1;
        m_tile   = 0;
        fresh    = 1'b1;
      end
      if (in_layer) begin
        m_first = (m_tile == 0);
        m_last  = (m_tile == int'(m_desc.tile_n) - 1);
        m_acc   = ROW_W'(m_tile * int'(m_desc.rows_per_tile));
        check("ctx_first", n_tile_is_first_o, m_first);
        check("ctx_last", n_tile_is_last_o, m_last);
        check("ctx_row", already_compute_row_o, m_acc);
        check("ctx_bias", is_bias_o, m_desc.flags[3] & m_first);
        check("ctx_ppu", need_ppu_o, m_last & (m_desc.flags[0] | m_desc.flags[2]));
      end else begin
        check("ctx_idle", {n_tile_is_first_o, n_tile_is_last_o, is_bias_o, need_ppu_o}, 4'd0);
      end
      if (pass_done_i && in_layer && !fresh) begin
        if (m_tile == int'(m_desc.tile_n) - 1) begin
          in_layer     = 1'b0;
          done_pending = 1'b1;
        end else begin
          m_tile++;
        end
      end
      if (abort_i) begin
        in_layer     = 1'b0;
        done_pending = 1'b0;
        exp_q.delete();
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    logic [15:0] tn;
    run_en_i = 1'b0; abort_i = 1'b0; desc_valid_i = 1'b0;
    desc_i = '0; pass_done_i = 1'b0;

    repeat (3) tick();
    check_reset("rst");
    rst_n = 1'b1;
    tick();
    check_reset("post_rst");

    // Single layer: tile_n=3, rows=4, bias+ppu flags; push-to-uLD latency.
    run_en_i = 1'b1;
    push(mk(6'd5, 2'd1, 16'd3, 8'd4, 4'b1001));
    check("lat_load_uld", uld_en_o, 1'b0);
    check("lat_load_busy", busy_o, 1'b1);
    tick();
    check("lat_issue_uld", uld_en_o, 1'b1);
    run_until_idle(500);

    // Back-to-back layers.
    run_en_i = 1'b0;
    push(mk(6'd10, 2'd1, 16'd2, 8'd3, 4'b0100));
    push(mk(6'd11, 2'd2, 16'd1, 8'd5, 4'b1000));
    run_en_i = 1'b1;
    wait_uld(10);
    check("b2b_id_a", layer_id_o, 6'd10);
    tick(); pass_done_i = 1'b1;
    tick();
    tick(); pass_done_i = 1'b0;
    check("b2b_done", layer_done_o, 1'b1);
    tick();
    check("b2b_gap_uld", uld_en_o, 1'b0);
    check("b2b_gap_id", layer_id_o, 6'd10);
    tick();
    check("b2b_issue_uld", uld_en_o, 1'b1);
    check("b2b_issue_id", layer_id_o, 6'd11);
    run_until_idle(500);

    // Full queue: fill with run_en low, drop one extra, then drain in order.
    run_en_i = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      push(mk(6'(20 + i), 2'($urandom_range(0, 3)), 16'($urandom_range(1, 4)),
              8'($urandom_range(0, 255)), 4'($urandom_range(0, 15))));
    check("full_ready", desc_ready_o, 1'b0);
    push(mk(6'd30, 2'd0, 16'd2, 8'd1, 4'b0001));
    check("full_ready_after_drop", desc_ready_o, 1'b0);
    check("full_not_busy", busy_o, 1'b0);
    run_en_i = 1'b1;
    run_until_idle(2000);

    // Illegal descriptor: sticky error, no load, next one still runs.
    check("err_clear", err_o, 1'b0);
    push(mk(6'd40, 2'd0, 16'd0, 8'd7, 4'b1111));
    push(mk(6'd41, 2'd3, 16'd2, 8'd6, 4'b0101));
    run_until_idle(500);
    check("err_set", err_o, 1'b1);
    push(mk(6'd42, 2'd1, 16'd1, 8'd2, 4'b1100));
    run_until_idle(500);
    check("err_sticky", err_o, 1'b1);

    // Abort mid-RUN with two descriptors still queued.
    run_en_i = 1'b0;
    push(mk(6'd50, 2'd0, 16'd4, 8'd7, 4'b0001));
    push(mk(6'd51, 2'd1, 16'd4, 8'd7, 4'b0001));
    push(mk(6'd52, 2'd2, 16'd4, 8'd7, 4'b0001));
    run_en_i = 1'b1;
    wait_uld(10);
    tick(); pass_done_i = 1'b1;
    tick(); pass_done_i = 1'b0;
    tick();
    tick(); abort_i = 1'b1;
    tick(); abort_i = 1'b0;
    check("abort_idle", busy_o, 1'b0);
    check("abort_ready", desc_ready_o, 1'b1);
    check("abort_no_done", layer_done_o, 1'b0);
    check("abort_acc", already_compute_row_o, '0);
    check("abort_err_kept", err_o, 1'b1);
    pass_done_i = 1'b1;
    repeat (6) begin
      tick();
      check("abort_pass_ignored", busy_o, 1'b0);
    end
    pass_done_i = 1'b0;
    m_occ = 0;
    push(mk(6'd53, 2'd3, 16'd2, 8'd9, 4'b0100));
    run_until_idle(500);

    // Asynchronous reset mid-layer at tile_idx=2.
    push(mk(6'd60, 2'd2, 16'd5, 8'd9, 4'b0101));
    wait_uld(10);
    tick(); pass_done_i = 1'b1;
    tick();
    tick(); pass_done_i = 1'b0;
    check("pre_rst_acc", already_compute_row_o, 10'd18);
    #1 rst_n = 1'b0;
    #1 check_reset("mid_rst");
    tick();
    rst_n = 1'b1;
    tick();
    check("post_mid_rst_busy", busy_o, 1'b0);
    m_occ = 0;

    // Randomised bursts: occasional illegal tiles, random run_en gating.
    for (int it = 0; it < 40; it++) begin
      run_en_i = 1'($urandom_range(0, 1));
      n = $urandom_range(1, DEPTH);
      for (int k = 0; k < n; k++) begin
        tn = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(1, 8));
        push(mk(6'($urandom_range(0, 63)), 2'($urandom_range(0, 3)), tn,
                8'($urandom_range(0, 255)), 4'($urandom_range(0, 15))));
      end
      run_en_i = 1'b1;
      run_until_idle(3000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dla_layer_sequencer.md
# dla_layer_sequencer

Multi-layer sequencer placed in front of the DLA controller. It buffers a queue of packed layer descriptors and issues them one at a time as a single-cycle uLD load. It then tracks pass completions to drive the per-tile context signals that the token engine needs: first/last tile, already-computed row offset, bias enable and PPU enable. It replaces the previous constant tie-offs of those signals and enables back-to-back layer execution with no host intervention.

## Interface

**Parameters**
- DESC_DEPTH, default 4: descriptor queue depth; must be a power of two, at least 2.
- TILE_W, default 16: width of the tile count and tile index.
- ROW_W, default 32: width of the already-computed-row accumulator.

**Ports** (clock and reset first)
- clk, input, 1: clock.
- rst_n, input, 1: asynchronous, active-low reset.
- run_en_i, input, 1: allows the sequencer to leave IDLE.
- abort_i, input, 1: synchronous abort and queue flush.
- desc_valid_i, input, 1: descriptor push request.
- desc_ready_o, output, 1: queue not full.
- desc_i, input, DESC_W (36): packed desc_t.
- uld_en_o, output, 1: one-cycle layer load strobe to the controller.
- layer_id_o, output, 6: field of the active descriptor.
- layer_type_o, output, 2: field of the active descriptor.
- flags_o, output, 4: field of the active descriptor.
- pass_done_i, input, 1: one-cycle pulse; each pulse equals one completed tile.
- n_tile_is_first_o, output, 1: current tile is tile 0.
- n_tile_is_last_o, output, 1: current tile is tile tile_n-1.
- already_compute_row_o, output, ROW_W: rows completed in the layer before the current tile.
- is_bias_o, output, 1: flags[3] and n_tile_is_first_o.
- need_ppu_o, output, 1: n_tile_is_last_o and (flags[0] or flags[2]).
- layer_done_o, output, 1: one-cycle pulse after the last tile of a layer.
- busy_o, output, 1: state is not IDLE.
- err_o, output, 1: sticky flag for an illegal descriptor (tile_n = 0).

## Operation

**State machine:** IDLE, LOAD, ISSUE, RUN, DONE.

- **IDLE:** go to LOAD when run_en_i is high and the queue is not empty.
- **LOAD:** pop one descriptor and register it into the active registers.
  - If tile_n = 0: set err_o, do not issue, go to IDLE.
  - Otherwise clear tile_idx and the row accumulator, then go to ISSUE.
- **ISSUE:** assert uld_en_o for exactly one cycle while all layer fields are stable, then go to RUN.
- **RUN:** on each pass_done_i:
  - If tile_idx = tile_n-1, go to DONE.
  - Otherwise increment tile_idx and add rows_per_tile to the accumulator.
- **DONE:** pulse layer_done_o for one cycle.
  - If run_en_i is high and the queue is not empty, go to LOAD (back-to-back layers).
  - Otherwise go to IDLE.

**Context outputs**
- Decoded combinationally from registered tile_idx, tile_n and flags.
- Valid from the ISSUE cycle onward, and again from the cycle after each pass_done_i.

**Arithmetic**
- The accumulator uses unsigned add and wraps modulo 2^ROW_W; no multiplier is used.
- The comparison against tile_n-1 is done at TILE_W width.

**Abort**
- abort_i has priority over every transition.
- On the next edge: state goes to IDLE, the queue is emptied, the active registers and counters clear, and no layer_done_o pulse is issued. err_o is kept.

**err_o** clears only on reset.

**Queue rules**
- desc_ready_o = !full.
- A push when full is dropped.
- A simultaneous push and pop when full: the push is still rejected because ready is low.
- A push and pop in the same cycle when neither full nor empty leaves the count unchanged.
- Wrap-around of the read and write pointers is modulo DESC_DEPTH.

**pass_done_i outside RUN** is ignored.

## Timing

- **Reset values:** every output is 0, except desc_ready_o, which is 1.
- **Push-to-uld_en_o latency:** with run_en_i high and the queue empty, a descriptor pushed at cycle t reaches LOAD at t+1 and ISSUE at t+2 (uld_en_o high at t+2).
- **pass_done_i to context update:** pass_done_i at cycle t updates the context outputs at t+1.
- **Last pass to layer_done_o:** the final pass_done_i at cycle t gives layer_done_o at t+1 and uld_en_o for the next queued layer at t+3.
- **Reset asserted mid-layer:** all state clears immediately (asynchronous); there is no partial layer_done_o.

## Structure

- **Package dla_seq_pkg:**
  - desc_t, packed as: layer_id[35:30], layer_type[29:28], tile_n[27:12], rows_per_tile[11:4], flags[3:0].
  - DESC_W = 36.
  - The state enum seq_state_e.
- **Sub-module dla_desc_fifo:** a synchronous FIFO parameterised by depth and width, with flush input, full, empty and a count output.
- The sequencer FSM, counters and context decode stay in the top module.

## Test plan

1. **Single layer:** push a descriptor with tile_n=3, rows_per_tile=4, flags=4'b1001, then send 3 pass_done_i pulses.
   - already_compute_row_o steps 0, 4, 8.
   - is_bias_o is high only on tile 0.
   - need_ppu_o is high only on tile 2.
   - One layer_done_o pulse follows.
2. **Back-to-back layers:** queue 2 descriptors.
   - uld_en_o for layer 2 comes exactly 2 cycles after layer_done_o of layer 1.
   - layer_id_o changes at the ISSUE cycle.
3. **Full queue:** fill DESC_DEPTH entries with run_en_i low.
   - desc_ready_o=0.
   - A fifth push is dropped.
   - Raise run_en_i: exactly DESC_DEPTH layers execute, in order.
4. **Illegal descriptor:** tile_n=0.
   - err_o sets and stays high.
   - No uld_en_o.
   - The next valid descriptor still runs normally.
5. **Abort mid-RUN:** assert abort_i after 1 of 4 passes with 2 descriptors queued.
   - IDLE on the next cycle.
   - Queue empty, desc_ready_o=1.
   - No layer_done_o.
   - Later pass_done_i pulses are ignored.
6. **Reset mid-layer:** assert rst_n low during RUN with tile_idx=2.
   - All outputs return to their reset values immediately.
   - After release, busy_o=0.
